// File: rtl/chip8_sprite_draw_if.sv
// chip8_sprite_draw_if
//   Memory-side bundle of the CHIP-8 sprite drawer: the RAM read port, the
//   video (VRAM) read/write port and the shared read-data bus.
//   master : the sprite drawer (issues requests, consumes responses)
//   slave  : the memory (accepts requests, returns rvalid + data)
//   ram_addr_out/ram_valid_out, ram_ready_in/ram_rvalid_in       RAM read port
//   vid_addr_out/vid_we_out/vid_data_out/vid_valid_out,
//   vid_ready_in/vid_rvalid_in                                   video port
//   mem_data_in                                                  shared read data
interface chip8_sprite_draw_if #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned VID_ADDR_WIDTH = 16
);
  logic [11:0]               ram_addr_out;
  logic                      ram_valid_out;
  logic                      ram_ready_in;
  logic                      ram_rvalid_in;
  logic [VID_ADDR_WIDTH-1:0] vid_addr_out;
  logic                      vid_we_out;
  logic [WIDTH-1:0]          vid_data_out;
  logic                      vid_valid_out;
  logic                      vid_ready_in;
  logic                      vid_rvalid_in;
  logic [WIDTH-1:0]          mem_data_in;

  modport master (
    output ram_addr_out, ram_valid_out,
    output vid_addr_out, vid_we_out, vid_data_out, vid_valid_out,
    input  ram_ready_in, ram_rvalid_in, vid_ready_in, vid_rvalid_in, mem_data_in
  );

  modport slave (
    input  ram_addr_out, ram_valid_out,
    input  vid_addr_out, vid_we_out, vid_data_out, vid_valid_out,
    output ram_ready_in, ram_rvalid_in, vid_ready_in, vid_rvalid_in, mem_data_in
  );
endinterface

// File: rtl/chip8_sprite_draw.sv
// chip8_sprite_draw
//   Executes CHIP-8 DXYN. Fetches N sprite rows from RAM starting at I and
//   XORs each row into the 64x32 1bpp frame buffer (8 bytes per line, MSB is
//   the leftmost pixel) with read-modify-write, accumulating the VF collision.
//   clk_in, rst_in (sync, active low)
//   start_in, x_in, y_in, n_in, i_in   draw command, latched when accepted in IDLE
//   busy_out, done_out, collision_out  status; collision valid from done_out
//   mem_if (master)                    RAM read port and video read/write port
module chip8_sprite_draw #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned VID_ADDR_WIDTH = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic [7:0]          x_in,
  input  logic [7:0]          y_in,
  input  logic [3:0]          n_in,
  input  logic [11:0]         i_in,
  output logic                busy_out,
  output logic                done_out,
  output logic                collision_out,
  chip8_sprite_draw_if.master mem_if
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SPR_REQ,
    S_SPR_WAIT,
    S_L_RD,
    S_L_RWAIT,
    S_L_WR,
    S_L_WWAIT,
    S_R_RD,
    S_R_RWAIT,
    S_R_WR,
    S_R_WWAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [5:0]                x0_q, x0_d;
  logic [4:0]                y0_q, y0_d;
  logic [3:0]                n_q, n_d;
  logic [11:0]               i_q, i_d;
  logic [3:0]                row_q, row_d;
  logic [WIDTH-1:0]          part_l_q, part_l_d;
  logic [WIDTH-1:0]          part_r_q, part_r_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      coll_q, coll_d;
  logic [11:0]               ram_addr_q, ram_addr_d;
  logic                      ram_valid_q, ram_valid_d;
  logic [VID_ADDR_WIDTH-1:0] vid_addr_q, vid_addr_d;
  logic                      vid_we_q, vid_we_d;
  logic [WIDTH-1:0]          vid_data_q, vid_data_d;
  logic                      vid_valid_q, vid_valid_d;

  logic [5:0]                row_y;
  logic [2:0]                col;
  logic [2:0]                shamt;
  logic [2*WIDTH-1:0]        split;
  logic                      r_clipped;
  logic [VID_ADDR_WIDTH-1:0] addr_l;
  logic [VID_ADDR_WIDTH-1:0] addr_r;

  // Sprite row positioned across two bytes: upper half lands in byte col,
  // lower half spills into byte col+1.
  assign row_y     = {1'b0, y0_q} + {2'b00, row_q};
  assign col       = x0_q[5:3];
  assign shamt     = x0_q[2:0];
  assign split     = {mem_if.mem_data_in, {WIDTH{1'b0}}} >> shamt;
  assign r_clipped = (col == 3'd7);
  assign addr_l    = VID_ADDR_WIDTH'({row_y[4:0], col});
  assign addr_r    = VID_ADDR_WIDTH'({row_y[4:0], col + 3'd1});

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    n_d         = n_q;
    i_d         = i_q;
    row_d       = row_q;
    part_l_d    = part_l_q;
    part_r_d    = part_r_q;
    busy_d      = busy_q;
    done_d      = done_q;
    coll_d      = coll_q;
    ram_addr_d  = ram_addr_q;
    ram_valid_d = ram_valid_q;
    vid_addr_d  = vid_addr_q;
    vid_we_d    = vid_we_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = vid_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          x0_d    = x_in[5:0];
          y0_d    = y_in[4:0];
          n_d     = n_in;
          i_d     = i_in;
          row_d   = '0;
          coll_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SPR_REQ;
        end
      end

      S_SPR_REQ: begin
        // Rows falling off the bottom end the draw; nothing wraps.
        if (row_q == n_q || row_y >= 6'd32) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          ram_valid_d = 1'b1;
          ram_addr_d  = i_q + 12'(row_q);
          state_d     = S_SPR_WAIT;
        end
      end

      S_SPR_WAIT: begin
        if (ram_valid_q) begin
          if (mem_if.ram_ready_in) ram_valid_d = 1'b0;
        end else if (mem_if.ram_rvalid_in) begin
          part_l_d = split[2*WIDTH-1:WIDTH];
          part_r_d = r_clipped ? '0 : split[WIDTH-1:0];
          if (split[2*WIDTH-1:WIDTH] != '0)
            state_d = S_L_RD;
          else if (!r_clipped && split[WIDTH-1:0] != '0)
            state_d = S_R_RD;
          else
            state_d = S_NEXT;
        end
      end

      S_L_RD: begin
        vid_valid_d = 1'b1;
        vid_we_d    = 1'b0;
        vid_addr_d  = addr_l;
        state_d     = S_L_RWAIT;
      end

      S_L_RWAIT: begin
        if (vid_valid_q) begin
          if (mem_if.vid_ready_in) vid_valid_d = 1'b0;
        end else if (mem_if.vid_rvalid_in) begin
          vid_data_d = mem_if.mem_data_in ^ part_l_q;
          coll_d     = coll_q | (|(mem_if.mem_data_in & part_l_q));
          state_d    = S_L_WR;
        end
      end

      S_L_WR: begin
        vid_valid_d = 1'b1;
        vid_we_d    = 1'b1;
        state_d     = S_L_WWAIT;
      end

      S_L_WWAIT: begin
        if (vid_valid_q) begin
          if (mem_if.vid_ready_in) vid_valid_d = 1'b0;
        end else if (mem_if.vid_rvalid_in) begin
          state_d = (part_r_q != '0) ? S_R_RD : S_NEXT;
        end
      end

      S_R_RD: begin
        vid_valid_d = 1'b1;
        vid_we_d    = 1'b0;
        vid_addr_d  = addr_r;
        state_d     = S_R_RWAIT;
      end

      S_R_RWAIT: begin
        if (vid_valid_q) begin
          if (mem_if.vid_ready_in) vid_valid_d = 1'b0;
        end else if (mem_if.vid_rvalid_in) begin
          vid_data_d = mem_if.mem_data_in ^ part_r_q;
          coll_d     = coll_q | (|(mem_if.mem_data_in & part_r_q));
          state_d    = S_R_WR;
        end
      end

      S_R_WR: begin
        vid_valid_d = 1'b1;
        vid_we_d    = 1'b1;
        state_d     = S_R_WWAIT;
      end

      S_R_WWAIT: begin
        if (vid_valid_q) begin
          if (mem_if.vid_ready_in) vid_valid_d = 1'b0;
        end else if (mem_if.vid_rvalid_in) begin
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        row_d   = row_q + 4'd1;
        state_d = S_SPR_REQ;
      end

      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      n_q         <= '0;
      i_q         <= '0;
      row_q       <= '0;
      part_l_q    <= '0;
      part_r_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      coll_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_valid_q <= 1'b0;
      vid_addr_q  <= '0;
      vid_we_q    <= 1'b0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      n_q         <= n_d;
      i_q         <= i_d;
      row_q       <= row_d;
      part_l_q    <= part_l_d;
      part_r_q    <= part_r_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      coll_q      <= coll_d;
      ram_addr_q  <= ram_addr_d;
      ram_valid_q <= ram_valid_d;
      vid_addr_q  <= vid_addr_d;
      vid_we_q    <= vid_we_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  assign busy_out             = busy_q;
  assign done_out             = done_q;
  assign collision_out        = coll_q;
  assign mem_if.ram_addr_out  = ram_addr_q;
  assign mem_if.ram_valid_out = ram_valid_q;
  assign mem_if.vid_addr_out  = vid_addr_q;
  assign mem_if.vid_we_out    = vid_we_q;
  assign mem_if.vid_data_out  = vid_data_q;
  assign mem_if.vid_valid_out = vid_valid_q;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// tb_chip8_sprite_draw
//   Drives DXYN commands into chip8_sprite_draw against a behavioural RAM/VRAM
//   responder (random ready stalls, 1-5 cycle rvalid latency, stray rvalids
//   while idle) and compares against a pixel-level reference of the frame buffer.
module tb_chip8_sprite_draw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  x, y;
  logic [3:0]  n;
  logic [11:0] i;
  logic        busy, done, coll;

  always #5 clk = ~clk;

  chip8_sprite_draw_if #(.WIDTH(8), .VID_ADDR_WIDTH(16)) bus ();

  chip8_sprite_draw #(.WIDTH(8), .VID_ADDR_WIDTH(16)) dut (
    .clk_in       (clk),
    .rst_in       (rst_n),
    .start_in     (start),
    .x_in         (x),
    .y_in         (y),
    .n_in         (n),
    .i_in         (i),
    .busy_out     (busy),
    .done_out     (done),
    .collision_out(coll),
    .mem_if       (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents as written by the DUT, and the reference frame buffer.
  logic [7:0]  ram_m   [4096];
  logic [7:0]  vram_m  [256];
  logic [7:0]  ref_vram[256];
  bit          touched [256];
  int unsigned ram_log [$];
  int          vid_xfers;
  int          proto_err = 0;
  bit          block_wr  = 1'b0;

  // Responder: one outstanding request, rvalid 1-5 cycles after the transfer.
  initial begin : responder
    bit          pend    = 1'b0;
    bit          pend_rm = 1'b0;
    int          cnt     = 0;
    logic [7:0]  rsp     = '0;
    bit          ram_hold = 1'b0, vid_hold = 1'b0;
    logic [11:0] ram_hold_addr = '0;
    logic [15:0] vid_hold_addr = '0;
    logic        vid_hold_we   = 1'b0;
    logic [7:0]  vid_hold_data = '0;
    bus.ram_ready_in  = 1'b0;
    bus.ram_rvalid_in = 1'b0;
    bus.vid_ready_in  = 1'b0;
    bus.vid_rvalid_in = 1'b0;
    bus.mem_data_in   = '0;
    forever begin
      @(negedge clk);
      bus.ram_rvalid_in = 1'b0;
      bus.vid_rvalid_in = 1'b0;
      // A response in flight is still delivered across a reset.
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend            = 1'b0;
          bus.mem_data_in = rsp;
          if (pend_rm) bus.ram_rvalid_in = 1'b1;
          else         bus.vid_rvalid_in = 1'b1;
        end
      end else if (rst_n && !busy && $urandom_range(0, 3) == 0) begin
        bus.mem_data_in = 8'($urandom);
        if ($urandom_range(0, 1) == 0) bus.ram_rvalid_in = 1'b1;
        else                           bus.vid_rvalid_in = 1'b1;
      end
      if (!rst_n) begin
        bus.ram_ready_in = 1'b0;
        bus.vid_ready_in = 1'b0;
        ram_hold = 1'b0;
        vid_hold = 1'b0;
      end else begin
        if (ram_hold && (!bus.ram_valid_out || bus.ram_addr_out != ram_hold_addr)) proto_err++;
        if (vid_hold && (!bus.vid_valid_out || bus.vid_addr_out != vid_hold_addr ||
                         bus.vid_we_out != vid_hold_we ||
                         (vid_hold_we && bus.vid_data_out != vid_hold_data))) proto_err++;
        bus.ram_ready_in = 1'($urandom_range(0, 1));
        bus.vid_ready_in = (block_wr && bus.vid_we_out) ? 1'b0 : 1'($urandom_range(0, 1));
        if (bus.ram_valid_out && bus.ram_ready_in) begin
          if (pend || bus.ram_rvalid_in || bus.vid_rvalid_in) proto_err++;
          pend    = 1'b1;
          pend_rm = 1'b1;
          cnt     = int'($urandom_range(1, 5));
          rsp     = ram_m[bus.ram_addr_out];
          ram_log.push_back(32'(bus.ram_addr_out));
        end
        if (bus.vid_valid_out && bus.vid_ready_in) begin
          if (pend || bus.vid_addr_out > 16'd255) proto_err++;
          pend    = 1'b1;
          pend_rm = 1'b0;
          cnt     = int'($urandom_range(1, 5));
          vid_xfers++;
          touched[bus.vid_addr_out[7:0]] = 1'b1;
          rsp = vram_m[bus.vid_addr_out[7:0]];
          if (bus.vid_we_out) vram_m[bus.vid_addr_out[7:0]] = bus.vid_data_out;
        end
        ram_hold      = bus.ram_valid_out && !bus.ram_ready_in;
        ram_hold_addr = bus.ram_addr_out;
        vid_hold      = bus.vid_valid_out && !bus.vid_ready_in;
        vid_hold_addr = bus.vid_addr_out;
        vid_hold_we   = bus.vid_we_out;
        vid_hold_data = bus.vid_data_out;
      end
    end
  end

  // Pixel-level reference: XOR each lit sprite pixel, clip right and bottom.
  int unsigned exp_reads[$];

  task automatic ref_draw(input logic [7:0] xx, input logic [7:0] yy, input logic [3:0] nn,
                          input logic [11:0] ii, output logic ec, output int exf);
    int unsigned x0 = 32'(xx) % 64;
    int unsigned y0 = 32'(yy) % 32;
    ec  = 1'b0;
    exf = 0;
    exp_reads.delete();
    for (int unsigned r = 0; r < 32'(nn); r++) begin
      int unsigned yr = y0 + r;
      int unsigned a  = (32'(ii) + r) % 4096;
      logic [7:0]  spr;
      bit          hit[2];
      if (yr >= 32) break;
      exp_reads.push_back(a);
      spr    = ram_m[a];
      hit[0] = 1'b0;
      hit[1] = 1'b0;
      for (int unsigned b = 0; b < 8; b++) begin
        int unsigned px = x0 + b;
        int unsigned idx, bp;
        if (!spr[7 - b] || px >= 64) continue;
        idx = yr * 8 + px / 8;
        bp  = 7 - px % 8;
        if (ref_vram[idx][bp]) ec = 1'b1;
        ref_vram[idx][bp] = ~ref_vram[idx][bp];
        hit[px / 8 - x0 / 8] = 1'b1;
      end
      exf += 2 * (int'(hit[0]) + int'(hit[1]));
    end
  endtask

  task automatic draw(input string tag, input logic [7:0] xx, input logic [7:0] yy,
                      input logic [3:0] nn, input logic [11:0] ii,
                      output logic cv, output int lat);
    logic ec;
    int   exf;
    int   diffs = 0;
    ref_draw(xx, yy, nn, ii, ec, exf);
    @(negedge clk);
    x = xx; y = yy; n = nn; i = ii;
    start = 1'b1;
    ram_log.delete();
    vid_xfers = 0;
    foreach (touched[k]) touched[k] = 1'b0;
    @(negedge clk);
    start = 1'b0;
    x = 8'($urandom); y = 8'($urandom); n = 4'($urandom); i = 12'($urandom);
    chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 5000) begin
      @(negedge clk);
      lat++;
      start = (lat == 2);  // must be ignored while busy
    end
    start = 1'b0;
    if (!done) begin
      chk({tag, ".timeout"}, 32'd1, 32'd0);
      cv = 1'b0;
      return;
    end
    cv = coll;
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, ".collision"}, 32'(coll), 32'(ec));
    chk({tag, ".vid_xfers"}, 32'(vid_xfers), 32'(exf));
    chk({tag, ".ram_reads"}, 32'(ram_log.size()), 32'(exp_reads.size()));
    for (int k = 0; k < exp_reads.size() && k < ram_log.size(); k++)
      chk({tag, ".ram_addr"}, ram_log[k], exp_reads[k]);
    foreach (vram_m[k]) if (vram_m[k] !== ref_vram[k]) diffs++;
    chk({tag, ".vram_bytes_differ"}, 32'(diffs), 32'd0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".coll_hold"}, 32'(coll), 32'(cv));
  endtask

  initial begin : main
    logic cv;
    int   lat;
    int   guard;
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; n = '0; i = '0;
    foreach (ram_m[k]) ram_m[k] = 8'($urandom);
    foreach (vram_m[k]) begin vram_m[k] = '0; ref_vram[k] = '0; end
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.coll", 32'(coll), 32'd0);
    chk("rst.ram_valid", 32'(bus.ram_valid_out), 32'd0);
    chk("rst.vid_valid", 32'(bus.vid_valid_out), 32'd0);
    chk("rst.vid_we", 32'(bus.vid_we_out), 32'd0);
    chk("rst.ram_addr", 32'(bus.ram_addr_out), 32'd0);
    chk("rst.vid_addr", 32'(bus.vid_addr_out), 32'd0);
    chk("rst.vid_data", 32'(bus.vid_data_out), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    ram_m[12'h200] = 8'hF0;
    draw("t1", 8'd0, 8'd0, 4'd1, 12'h200, cv, lat);
    chk("t1.vram0", 32'(vram_m[0]), 32'hF0);
    chk("t1.no_byte1", 32'(touched[1]), 32'd0);
    chk("t1.coll", 32'(cv), 32'd0);

    ram_m[12'h300] = 8'hFF;
    draw("t2", 8'd4, 8'd2, 4'd1, 12'h300, cv, lat);
    chk("t2.vram16", 32'(vram_m[16]), 32'h0F);
    chk("t2.vram17", 32'(vram_m[17]), 32'hF0);
    chk("t2.coll", 32'(cv), 32'd0);

    draw("t3", 8'd4, 8'd2, 4'd1, 12'h300, cv, lat);
    chk("t3.vram16", 32'(vram_m[16]), 32'h00);
    chk("t3.vram17", 32'(vram_m[17]), 32'h00);
    chk("t3.coll", 32'(cv), 32'd1);
    chk("t3.xfers", 32'(vid_xfers), 32'd4);

    ram_m[12'h400] = 8'hFF;
    draw("t4", 8'd62, 8'd31, 4'd3, 12'h400, cv, lat);
    chk("t4.vram255", 32'(vram_m[255]), 32'h03);
    chk("t4.rows_fetched", 32'(ram_log.size()), 32'd1);
    chk("t4.xfers", 32'(vid_xfers), 32'd2);

    ram_m[12'hFFF] = 8'hFF;
    ram_m[12'h000] = 8'h81;
    draw("t5", 8'd70, 8'd40, 4'd2, 12'hFFF, cv, lat);
    chk("t5.read0", ram_log.size() > 0 ? ram_log[0] : 32'hDEAD, 32'hFFF);
    chk("t5.read1", ram_log.size() > 1 ? ram_log[1] : 32'hDEAD, 32'h000);
    chk("t5.vram64", 32'(vram_m[64]), 32'h03);
    chk("t5.vram65", 32'(vram_m[65]), 32'hFC);
    chk("t5.vram72", 32'(vram_m[72]), 32'h02);
    chk("t5.vram73", 32'(vram_m[73]), 32'h04);

    draw("t6n0", 8'($urandom), 8'($urandom), 4'd0, 12'($urandom), cv, lat);
    chk("t6n0.latency", 32'(lat), 32'd1);
    chk("t6n0.coll", 32'(cv), 32'd0);

    // Reset while the L write is being presented (writes held off).
    ram_m[12'h500] = 8'hAA;
    block_wr = 1'b1;
    @(negedge clk);
    x = 8'd8; y = 8'd3; n = 4'd2; i = 12'h500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(bus.vid_valid_out && bus.vid_we_out) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("rmid.reached_l_wr", 32'(bus.vid_valid_out && bus.vid_we_out), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmid.busy", 32'(busy), 32'd0);
    chk("rmid.done", 32'(done), 32'd0);
    chk("rmid.coll", 32'(coll), 32'd0);
    chk("rmid.ram_valid", 32'(bus.ram_valid_out), 32'd0);
    chk("rmid.vid_valid", 32'(bus.vid_valid_out), 32'd0);
    chk("rmid.vid_we", 32'(bus.vid_we_out), 32'd0);
    chk("rmid.vid_addr", 32'(bus.vid_addr_out), 32'd0);
    chk("rmid.vid_data", 32'(bus.vid_data_out), 32'd0);
    rst_n = 1'b1;
    block_wr = 1'b0;
    repeat (6) @(negedge clk);
    draw("after_rst", 8'd8, 8'd3, 4'd2, 12'h500, cv, lat);

    for (int t = 0; t < 40; t++)
      draw($sformatf("rnd%0d", t), 8'($urandom), 8'($urandom), 4'($urandom),
           12'($urandom), cv, lat);

    chk("protocol_violations", 32'(proto_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
